// File: rtl/timer_capture.sv
// timer_capture: input-capture unit. A prescaled free-running counter is
// latched into capture_val on a selected edge of the asynchronous cap_in pin.
// Optional build macro CAPTURE_FILTER_EN inserts a 3-cycle glitch filter
// between the synchronizer and the edge detector (adds 2 cycles of latency).
module timer_capture #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned SYNC_STAGES = 2   // minimum 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [15:0]      prescaler,
  input  logic [1:0]       edge_sel,
  input  logic             one_shot,
  input  logic             clear,
  input  logic             cap_in,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] capture_val,
  output logic             valid,
  output logic             overrun,
  output logic             overflow,
  output logic             armed
);

  typedef enum logic [0:0] {
    ARMED = 1'b0,
    HELD  = 1'b1
  } state_t;

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_lvl;
  logic                   level;
  logic                   prev_q;
  logic                   rise;
  logic                   fall;
  logic                   edge_hit;
  logic                   accept;
  logic [15:0]            div_q;
  logic                   tick;
  logic                   wrap;
  logic [WIDTH-1:0]       count_q;
  logic [WIDTH-1:0]       capture_q;
  logic                   valid_q;
  logic                   overrun_q;
  logic                   overflow_q;
  logic                   armed_q;

  // Two-or-more flop synchronizer for the asynchronous pin; runs regardless of en.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], cap_in};
    end
  end

  assign sync_lvl = sync_q[SYNC_STAGES-1];

`ifdef CAPTURE_FILTER_EN
  logic hist_q;
  logic filt_q;
  logic early_lvl;

  // The stage ahead of the synchronizer output gives the third sample, so the
  // window {next, current, previous} spans 3 consecutive synchronized cycles
  // and the filtered level trails the raw level by exactly 2 cycles.
  assign early_lvl = sync_q[SYNC_STAGES-2];

  // Glitch filter: follow the synchronized level only once it has held for 3 cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist_q <= 1'b0;
      filt_q <= 1'b0;
    end else begin
      hist_q <= sync_lvl;
      if ((early_lvl == sync_lvl) && (sync_lvl == hist_q)) begin
        filt_q <= sync_lvl;
      end
    end
  end

  assign level = filt_q;
`else
  assign level = sync_lvl;
`endif

  // Previous-sample register; keeps tracking while disabled so enabling sees no stale edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= level;
    end
  end

  assign rise     = level & ~prev_q;
  assign fall     = ~level & prev_q;
  assign edge_hit = (edge_sel[0] & rise) | (edge_sel[1] & fall);
  assign accept   = en && (state_q == ARMED) && edge_hit;

  // A divider already above a newly lowered prescaler wraps at the next check.
  assign tick = en && (div_q >= prescaler);
  assign wrap = tick && (count_q == '1);

  // Prescale divider and free-running counter; both hold while en=0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q   <= '0;
      count_q <= '0;
    end else if (en) begin
      if (tick) begin
        div_q   <= '0;
        count_q <= count_q + WIDTH'(1);
      end else begin
        div_q   <= div_q + 16'd1;
      end
    end
  end

  // Sticky overflow flag; a wrap in the same cycle as clear keeps it set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= (overflow_q & ~clear) | wrap;
    end
  end

  // Capture FSM with registered capture value, status flags and armed indication.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ARMED;
      armed_q   <= 1'b1;
      capture_q <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (accept) begin
        // Capture outranks a coincident clear; newest value always wins.
        capture_q <= count_q;
        valid_q   <= 1'b1;
        overrun_q <= clear ? 1'b0 : (overrun_q | valid_q);
        if (one_shot) begin
          state_q <= HELD;
          armed_q <= 1'b0;
        end
      end else begin
        if (clear) begin
          valid_q   <= 1'b0;
          overrun_q <= 1'b0;
        end
        if ((state_q == HELD) && clear) begin
          state_q <= ARMED;
          armed_q <= 1'b1;
        end
      end
    end
  end

  assign count       = count_q;
  assign capture_val = capture_q;
  assign valid       = valid_q;
  assign overrun     = overrun_q;
  assign overflow    = overflow_q;
  assign armed       = armed_q;

endmodule

// File: doc/timer_capture.md
Name: timer_capture

Overview:
- Input-capture companion to the timer counter; the counter generates events from a count, and this block measures externally generated events against a count.
- A free-running prescaled counter runs internally. A selected edge on an asynchronous external pin latches the current count into a capture register and raises a status flag.
- It sits beside the timer in the peripheral block, and its outputs feed the register/interrupt layer.

Parameters:
- WIDTH, 16, width of the free-running counter and the capture register.
- SYNC_STAGES, 2, number of flops in the cap_in synchronizer (minimum 2).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, synchronous, active-low.
- en  input  1  enables counting and capture.
- prescaler  input  16  tick divider: counter advances every prescaler+1 enabled clk cycles.
- edge_sel  input  2  00 none, 01 rising, 10 falling, 11 both.
- one_shot  input  1  1 = disarm after first capture until clear.
- clear  input  1  single-cycle acknowledge; clears valid, overrun and overflow and re-arms.
- cap_in  input  1  asynchronous external event pin.
- count  output  WIDTH  live free-running count.
- capture_val  output  WIDTH  latched count at the last accepted edge.
- valid  output  1  capture pending.
- overrun  output  1  sticky; an edge was accepted while valid was already 1.
- overflow  output  1  sticky; count wrapped from all-ones to 0.
- armed  output  1  1 when the FSM is in ARMED.

Behaviour:
- Reset (rst_n=0 at a clk edge): every flop cleared, including the synchronizer and the previous-sample register. count=0, capture_val=0, valid=0, overrun=0, overflow=0, FSM=ARMED (armed=1).
- Prescaler:
  - Internal divider counts 0..prescaler while en=1.
  - Tick when divider==prescaler; the divider then returns to 0.
  - prescaler=0 gives a tick every cycle.
  - A prescaler change takes effect at the next divider wrap. If the divider already exceeds the new value, it wraps at the next tick check.
- Counter: count+1 on each tick, modulo 2^WIDTH. The all-ones to 0 transition sets overflow.
- en=0:
  - Divider and count hold.
  - Synchronizer and previous-sample register keep updating, so enabling never sees a stale edge.
  - Edges are ignored.
- Edge detect: compare the synchronizer output s with the registered previous sample p.
  - Rising = s&~p; falling = ~s&p; edge_sel masks them.
- Latency: an edge on cap_in, with setup met before clk edge E, gives valid=1 after edge E+SYNC_STAGES.
  - capture_val = count value visible in the cycle before that edge (pre-increment).
- FSM states:
  - ARMED: accepted edge -> capture_val<=count, valid<=1. If valid was already 1 (and clear not asserted this cycle), overrun<=1 and newest value wins. If one_shot=1, go to HELD.
  - HELD: edges ignored, capture_val frozen. clear -> ARMED.
- clear:
  - Clears valid, overrun and overflow next edge.
  - Does not reset count or the divider.
- Simultaneous events:
  - Capture and clear in the same cycle: capture wins; valid=1, overrun=0, FSM per one_shot.
  - Wrap and clear in the same cycle: overflow=1.
- Reset asserted mid-operation: all state returns to reset values at that edge. A pending edge in the synchronizer is discarded.
- edge_sel=00: no captures; counter still runs.

Optional Feature:
- Macro: CAPTURE_FILTER_EN.
- Defined: a glitch filter sits after the synchronizer. The filtered level changes only after the synchronized input holds a new value for 3 consecutive clk cycles. Edge detect uses the filtered level, and latency grows by 2 cycles (valid after E+SYNC_STAGES+2). Pulses shorter than 3 cycles are never captured. The filter is reset to 0.
- Not defined: the synchronizer output feeds edge detect directly.

Test Plan:
- Rising capture: prescaler=0, edge_sel=01, one_shot=0, en=1; cap_in rises while count=20 -> valid=1 two edges later with capture_val=22, overrun=0.
- Prescale and wrap: WIDTH=16, prescaler=3, en=1 for 4*65536 cycles -> count returns to 0 and overflow=1. Check count increments exactly every 4 cycles; clear -> overflow=0, count unaffected.
- Overrun: edge_sel=11, a pulse on cap_in gives two captures with no clear in between -> valid=1, overrun=1, capture_val = count at the falling edge; clear -> all flags 0.
- One-shot: one_shot=1, three rising edges -> only the first is captured, armed=0, capture_val unchanged. Clear then a new edge -> second capture accepted, armed=0 again.
- Collision and enable: a capture lands in the same cycle as clear -> valid=1, overrun=0. With en=0, hold cap_in high, then assert en -> no capture and count resumes from its held value.
- Filter (with CAPTURE_FILTER_EN): a 2-cycle high pulse gives no valid. A 3-cycle high pulse gives valid 4 edges after the rising edge.
